// File: rtl/mux_key_rev_cam.sv
//==============================================================================
// Module   : mux_key_rev_cam
// Brief    : Reverse-lookup table mapping a data value back to its key, with
//            a registered valid/ready search path.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux_key_rev_cam #(
    parameter  int NR_ENTRY = 4,
    parameter  int KEY_LEN  = 4,
    parameter  int DATA_LEN = 8,
    localparam int IDX_LEN  = $clog2(NR_ENTRY)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [IDX_LEN-1:0]  wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_LEN-1:0] req_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_hit,
    output logic [KEY_LEN-1:0]  rsp_key,
    output logic [IDX_LEN-1:0]  rsp_idx
);

    logic [NR_ENTRY-1:0] r_valid;
    logic [KEY_LEN-1:0]  r_key  [NR_ENTRY];
    logic [DATA_LEN-1:0] r_data [NR_ENTRY];

    logic [NR_ENTRY-1:0] w_wr_sel;
    logic [NR_ENTRY-1:0] w_match;
    logic                w_hit;
    logic [KEY_LEN-1:0]  w_key;
    logic [IDX_LEN-1:0]  w_idx;
    logic                w_accept;

    logic                r_rsp_valid;
    logic                r_rsp_hit;
    logic [KEY_LEN-1:0]  r_rsp_key;
    logic [IDX_LEN-1:0]  r_rsp_idx;

    // Out-of-range indices never decode, so such writes fall away naturally.
    generate
        for (genvar g = 0; g < NR_ENTRY; g++) begin : g_entry
            assign w_wr_sel[g] = wr_en && !clr && (wr_idx == IDX_LEN'(g));
            assign w_match[g]  = r_valid[g] && (r_data[g] == req_data);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (clr) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NR_ENTRY; i++) begin
                if (w_wr_sel[i]) begin
                    r_valid[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NR_ENTRY; i++) begin
            if (w_wr_sel[i]) begin
                r_key[i]  <= wr_key;
                r_data[i] <= wr_data;
            end
        end
    end

    // Scan from the top down so the lowest matching index is the last to win.
    always_comb begin
        w_hit = 1'b0;
        w_key = '0;
        w_idx = '0;
        for (int i = NR_ENTRY - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit = 1'b1;
                w_key = r_key[i];
                w_idx = IDX_LEN'(i);
            end
        end
    end

    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_key   <= '0;
            r_rsp_idx   <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= w_hit;
            r_rsp_key   <= w_key;
            r_rsp_idx   <= w_idx;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_key   = r_rsp_key;
    assign rsp_idx   = r_rsp_idx;

endmodule

`default_nettype wire

// File: tb/tb_mux_key_rev_cam.sv
//==============================================================================
// Module   : tb_mux_key_rev_cam
// Brief    : Self-checking bench for mux_key_rev_cam against a table model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mux_key_rev_cam;

    localparam int NR_ENTRY = 4;
    localparam int KEY_LEN  = 4;
    localparam int DATA_LEN = 8;
    localparam int IDX_LEN  = $clog2(NR_ENTRY);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                clr;
    logic                wr_en;
    logic [IDX_LEN-1:0]  wr_idx;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                req_valid;
    logic                req_ready;
    logic [DATA_LEN-1:0] req_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_hit;
    logic [KEY_LEN-1:0]  rsp_key;
    logic [IDX_LEN-1:0]  rsp_idx;

    int checks   = 0;
    int failures = 0;

    // Reference model: table contents plus the one pending response.
    bit                  m_valid [NR_ENTRY];
    logic [KEY_LEN-1:0]  m_key   [NR_ENTRY];
    logic [DATA_LEN-1:0] m_data  [NR_ENTRY];
    bit                  e_valid;
    bit                  e_hit;
    logic [KEY_LEN-1:0]  e_key;
    logic [IDX_LEN-1:0]  e_idx;

    mux_key_rev_cam #(
        .NR_ENTRY (NR_ENTRY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_key    (wr_key),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_key   (rsp_key),
        .rsp_idx   (rsp_idx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR_ENTRY; i++) m_valid[i] = 1'b0;
        e_valid = 1'b0;
        e_hit   = 1'b0;
        e_key   = '0;
        e_idx   = '0;
    endtask

    task automatic drive(input bit wen, input int widx, input int wkey, input int wdata,
                         input bit c, input bit rv, input int rd, input bit rr);
        wr_en     = wen;
        wr_idx    = IDX_LEN'(widx);
        wr_key    = KEY_LEN'(wkey);
        wr_data   = DATA_LEN'(wdata);
        clr       = c;
        req_valid = rv;
        req_data  = DATA_LEN'(rd);
        rsp_ready = rr;
    endtask

    // One clock: predict from the pre-edge model, cross the edge, then compare.
    task automatic step();
        bit                  acc;
        bit                  s_hit;
        logic [KEY_LEN-1:0]  s_key;
        logic [IDX_LEN-1:0]  s_idx;
        #1;
        check_eq("req_ready", 32'(req_ready), 32'(!e_valid || rsp_ready));
        acc   = req_valid && (!e_valid || rsp_ready);
        s_hit = 1'b0;
        s_key = '0;
        s_idx = '0;
        for (int i = 0; i < NR_ENTRY; i++) begin
            if (m_valid[i] && m_data[i] == req_data) begin
                s_hit = 1'b1;
                s_key = m_key[i];
                s_idx = IDX_LEN'(i);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin
            e_valid = 1'b1;
            e_hit   = s_hit;
            e_key   = s_key;
            e_idx   = s_idx;
        end else if (rsp_ready) begin
            e_valid = 1'b0;
        end
        if (clr) begin
            for (int i = 0; i < NR_ENTRY; i++) m_valid[i] = 1'b0;
        end else if (wr_en && int'(wr_idx) < NR_ENTRY) begin
            m_valid[wr_idx] = 1'b1;
            m_key[wr_idx]   = wr_key;
            m_data[wr_idx]  = wr_data;
        end
        check_eq("rsp_valid", 32'(rsp_valid), 32'(e_valid));
        if (e_valid) begin
            check_eq("rsp_hit", 32'(rsp_hit), 32'(e_hit));
            check_eq("rsp_key", 32'(rsp_key), 32'(e_key));
            check_eq("rsp_idx", 32'(rsp_idx), 32'(e_idx));
        end
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_rsp_hit",   32'(rsp_hit),   0);
        check_eq("rst_rsp_key",   32'(rsp_key),   0);
        check_eq("rst_rsp_idx",   32'(rsp_idx),   0);
        check_eq("rst_req_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Empty table search
        drive(0, 0, 0, 0, 0, 1, 'hAA, 1); step();
        check_eq("empty_hit", 32'(rsp_hit), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);    step();

        // Basic hit and back-to-back
        drive(1, 0, 'h3, 'h10, 0, 0, 0, 1); step();
        drive(1, 2, 'h7, 'h55, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1, 'h55, 1);   step();
        check_eq("b2b_key0", 32'(rsp_key), 'h7);
        drive(0, 0, 0, 0, 0, 1, 'h10, 1);   step();
        check_eq("b2b_key1", 32'(rsp_key), 'h3);
        check_eq("b2b_valid", 32'(rsp_valid), 1);

        // Lowest index wins on duplicate data
        drive(1, 1, 'hA, 'h22, 0, 0, 0, 1); step();
        drive(1, 3, 'hB, 'h22, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1, 'h22, 0);   step();
        check_eq("prio_idx", 32'(rsp_idx), 1);

        // Backpressure with a write to the matched entry during the stall
        for (int i = 0; i < 5; i++) begin
            drive(i == 2, 1, 'hC, 'h77, 0, 1, 'h10, 0); step();
            check_eq("stall_key", 32'(rsp_key), 'hA);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1); step();

        // Same-cycle write and search
        drive(1, 0, 'h9, 'h66, 0, 1, 'h66, 1); step();
        check_eq("samecyc_miss", 32'(rsp_hit), 0);
        drive(0, 0, 0, 0, 0, 1, 'h66, 1);      step();
        check_eq("samecyc_hit_key", 32'(rsp_key), 'h9);

        // Clear beats a same-cycle write
        drive(1, 2, 'h5, 'h88, 1, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1, 'h88, 1);   step();
        check_eq("clr_miss", 32'(rsp_hit), 0);
        drive(0, 0, 0, 0, 0, 1, 'h55, 1);   step();

        // Reset with a response pending
        drive(1, 0, 'h4, 'h44, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1, 'h44, 0);   step();
        check_eq("pre_rst_valid", 32'(rsp_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(rsp_valid), 0);
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        check_eq("rst_hold_ready", 32'(req_ready), 1);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 'h44, 1); step();
        check_eq("post_rst_miss", 32'(rsp_hit), 0);

        // Randomized traffic over a small data pool to provoke hits
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 2) == 0, int'($urandom_range(0, NR_ENTRY - 1)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
                  $urandom_range(0, 30) == 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 6)), $urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_key_rev_cam.md
# mux_key_rev_cam

Reverse-lookup table for the key/data LUT scheme: stores up to NR_ENTRY {key, data} pairs written at run time and answers "which key maps to this data?" queries. Searches are registered and use a valid/ready handshake on both request and response sides. Decode and CSR logic use it wherever a value must be mapped back to its selector, such as a one-hot or encoded operation back to an opcode field.

## Interface
Parameters:
- NR_ENTRY, 4 — number of table entries, ≥ 2
- KEY_LEN, 4 — key width
- DATA_LEN, 8 — data (search value) width
- IDX_LEN, $clog2(NR_ENTRY) — entry index width (derived, not overridden)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  invalidate all entries
- wr_en  in  1  write entry
- wr_idx  in  IDX_LEN  entry to write
- wr_key  in  KEY_LEN  key stored
- wr_data  in  DATA_LEN  data stored
- req_valid  in  1  search request valid
- req_ready  out  1  search request accepted when high with req_valid
- req_data  in  DATA_LEN  value to search for
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_hit  out  1  a valid entry matched
- rsp_key  out  KEY_LEN  key of matching entry, 0 on miss
- rsp_idx  out  IDX_LEN  index of matching entry, 0 on miss

## Operation
- **Storage:** NR_ENTRY entries, each with a valid bit, key and data.
- **Reset:** all valid bits 0. Key and data contents are don't-care.
- **Write:** when wr_en is high and clr is low, entry wr_idx takes {1, wr_key, wr_data} at the clock edge.
  - wr_idx ≥ NR_ENTRY: the write is ignored.
  - Rewriting a valid entry overwrites it.
- **Clear:** clr high clears all valid bits at the edge. clr has priority over a same-cycle wr_en, so that write is dropped.
- **Search:** accepted when req_valid && req_ready.
  - Compare req_data against the data of every valid entry in parallel.
  - Hit = any valid entry matches. On multiple matches, the lowest index wins.
  - Miss: rsp_hit = 0, rsp_key = 0, rsp_idx = 0.
- **Registered result:** the result is captured into the response register at the accepting edge, and rsp_valid is set.
- **Table state seen by a search:** the search sees contents before the edge. A same-cycle write or clear does not affect that search's result.
- **Response state:** one response register, no queue.
  - req_ready = !rsp_valid || rsp_ready, combinational.
  - rsp_valid clears on rsp_ready without a new accept.
  - rsp_valid stays set when a new request is accepted in the same cycle as the handshake (back-to-back).
- **Holding a response:** while rsp_valid && !rsp_ready, rsp_hit, rsp_key and rsp_idx hold stable. The table may still be written or cleared; the held response does not change.

## Timing
- **Reset values:** rsp_valid 0, rsp_hit 0, rsp_key 0, rsp_idx 0, all entries invalid. req_ready reads 1 during and after reset.
- **Latency:** one cycle from the accepting edge to rsp_valid.
- **Throughput:** one search per cycle while rsp_ready is held high.
- **Write visibility:** a write at edge N is visible to a search accepted at edge N+1 or later.
- **Reset mid-operation:** asserting rst_n low with a response pending drops it immediately (rsp_valid → 0 asynchronously) and invalidates the table.
- **Combinational path:** req_ready depends combinationally on rsp_ready. There is no combinational path from req_data to any output.

## Test plan
- **Reset then empty search:** after reset, search req_data=8'hAA → rsp_valid one cycle later, rsp_hit=0, rsp_key=0, rsp_idx=0.
- **Basic hit and back-to-back:**
  - Write idx0 {4'h3, 8'h10} and idx2 {4'h7, 8'h55}.
  - Search 8'h55 → hit=1, key=4'h7, idx=2.
  - Search 8'h10 back-to-back with rsp_ready=1 → next cycle hit=1, key=4'h3, idx=0.
  - Expect no bubble between the two responses.
- **Priority:** write idx1 and idx3 both with data 8'h22, keys 4'hA and 4'hB → search 8'h22 returns key=4'hA, idx=1.
- **Backpressure:**
  - Hold rsp_ready=0 after a hit response → req_ready=0 and outputs stable for 5 cycles, even with a write to the matched entry during the stall.
  - Raise rsp_ready → rsp_valid drops next cycle.
- **Same-cycle write and search:** search 8'h66 in the same cycle as a write of idx0 {4'h9, 8'h66} → miss. Repeat the search next cycle → hit, key=4'h9.
- **Clear and reset:**
  - clr together with wr_en to idx2 → all entries invalid, and a search of the written data misses.
  - Pulse rst_n low while rsp_valid=1 → rsp_valid=0 immediately and the table is empty.
